// File: rtl/sim_run_ctrl_if.sv
// Bundles the run-control command, CPU retire stream and status outputs of sim_run_ctrl.
// The PC trace port pair exists only when SIM_RUN_CTRL_TRACE_EN is defined.
interface sim_run_ctrl_if #(
    parameter int unsigned PC_WIDTH  = 32,
    parameter int unsigned CNT_WIDTH = 32
`ifdef SIM_RUN_CTRL_TRACE_EN
    ,
    parameter int unsigned TRACE_IDX_W = 3
`endif
);
    logic                 start;
    logic [PC_WIDTH-1:0]  pc;
    logic                 retire;
    logic                 cpu_reset;
    logic                 running;
    logic                 done;
    logic                 timeout;
    logic [CNT_WIDTH-1:0] cycle_count;
    logic [CNT_WIDTH-1:0] instr_count;
    logic [PC_WIDTH-1:0]  final_pc;
`ifdef SIM_RUN_CTRL_TRACE_EN
    logic [TRACE_IDX_W-1:0] trace_idx;
    logic [PC_WIDTH-1:0]    trace_pc;

    modport master (
        output start, pc, retire, trace_idx,
        input  cpu_reset, running, done, timeout, cycle_count, instr_count, final_pc, trace_pc
    );
    modport slave (
        input  start, pc, retire, trace_idx,
        output cpu_reset, running, done, timeout, cycle_count, instr_count, final_pc, trace_pc
    );
`else
    modport master (
        output start, pc, retire,
        input  cpu_reset, running, done, timeout, cycle_count, instr_count, final_pc
    );
    modport slave (
        input  start, pc, retire,
        output cpu_reset, running, done, timeout, cycle_count, instr_count, final_pc
    );
`endif
endinterface

// File: rtl/sim_run_ctrl.sv
// Run controller: sequences CPU reset, counts cycles/retires, detects jump-to-self halt and budget timeout.
// Optional PC trace ring buffer enabled by defining SIM_RUN_CTRL_TRACE_EN.
module sim_run_ctrl #(
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned CNT_WIDTH   = 32,
    parameter int unsigned RST_CYCLES  = 2,
    parameter int unsigned MAX_CYCLES  = 100,
    parameter int unsigned HALT_REPEAT = 4,
    parameter int unsigned TRACE_DEPTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    sim_run_ctrl_if.slave bus
);
    localparam int unsigned HOLD_W = (RST_CYCLES > 0) ? $clog2(RST_CYCLES + 1) : 1;
    localparam int unsigned REP_W  = $clog2(HALT_REPEAT + 1);
    localparam logic [CNT_WIDTH-1:0] MAX_C = CNT_WIDTH'(MAX_CYCLES);

    if (RST_CYCLES < 1 || HALT_REPEAT < 2 || TRACE_DEPTH < 2 ||
        (TRACE_DEPTH & (TRACE_DEPTH - 1)) != 0) begin : g_param_check
        $error("sim_run_ctrl: need RST_CYCLES>=1, HALT_REPEAT>=2, TRACE_DEPTH a power of 2 >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_RUN,
        S_DONE,
        S_TIMEOUT
    } state_t;

    state_t               state_q, state_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [CNT_WIDTH-1:0] cycle_q, cycle_d;
    logic [CNT_WIDTH-1:0] instr_q, instr_d;
    logic [PC_WIDTH-1:0]  fpc_q, fpc_d;
    logic [PC_WIDTH-1:0]  last_pc_q, last_pc_d;
    logic [REP_W-1:0]     rep_q, rep_d;
    logic                 cpu_reset_q, cpu_reset_d;
    logic                 running_q, running_d;
    logic                 done_q, done_d;
    logic                 timeout_q, timeout_d;
    logic                 start_accept;
    logic                 halt_hit;
    logic                 budget_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            cycle_q     <= '0;
            instr_q     <= '0;
            fpc_q       <= '0;
            last_pc_q   <= '0;
            rep_q       <= '0;
            cpu_reset_q <= 1'b1;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            cycle_q     <= cycle_d;
            instr_q     <= instr_d;
            fpc_q       <= fpc_d;
            last_pc_q   <= last_pc_d;
            rep_q       <= rep_d;
            cpu_reset_q <= cpu_reset_d;
            running_q   <= running_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        cycle_d      = cycle_q;
        instr_d      = instr_q;
        fpc_d        = fpc_q;
        last_pc_d    = last_pc_q;
        rep_d        = rep_q;
        cpu_reset_d  = cpu_reset_q;
        running_d    = running_q;
        done_d       = done_q;
        timeout_d    = timeout_q;
        start_accept = 1'b0;
        halt_hit     = 1'b0;
        budget_hit   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_TIMEOUT: begin
                if (bus.start) begin
                    start_accept = 1'b1;
                    state_d      = S_HOLD;
                    hold_d       = HOLD_W'(RST_CYCLES);
                    cycle_d      = '0;
                    instr_d      = '0;
                    fpc_d        = '0;
                    last_pc_d    = '0;
                    rep_d        = '0;
                    cpu_reset_d  = 1'b1;
                    running_d    = 1'b0;
                    done_d       = 1'b0;
                    timeout_d    = 1'b0;
                end
            end
            S_HOLD: begin
                // Leaving on the count-of-1 edge gives exactly RST_CYCLES cycles of cpu_reset after start.
                if (hold_q <= HOLD_W'(1)) begin
                    state_d     = S_RUN;
                    hold_d      = '0;
                    cpu_reset_d = 1'b0;
                    running_d   = 1'b1;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            S_RUN: begin
                if (cycle_q != '1) cycle_d = cycle_q + CNT_WIDTH'(1);
                if (bus.retire) begin
                    if (instr_q != '1) instr_d = instr_q + CNT_WIDTH'(1);
                    // rep_q==0 marks an empty tracker so the first retire always restarts at 1.
                    if (rep_q != '0 && bus.pc == last_pc_q) begin
                        rep_d = rep_q + REP_W'(1);
                    end else begin
                        rep_d     = REP_W'(1);
                        last_pc_d = bus.pc;
                    end
                    halt_hit = (rep_d == REP_W'(HALT_REPEAT));
                end
                budget_hit = (MAX_CYCLES != 0) && (cycle_d == MAX_C);
                if (halt_hit) begin
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                    fpc_d       = bus.pc;
                    cpu_reset_d = 1'b1;
                    running_d   = 1'b0;
                end else if (budget_hit) begin
                    state_d     = S_TIMEOUT;
                    timeout_d   = 1'b1;
                    cpu_reset_d = 1'b1;
                    running_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.cpu_reset   = cpu_reset_q;
    assign bus.running     = running_q;
    assign bus.done        = done_q;
    assign bus.timeout     = timeout_q;
    assign bus.cycle_count = cycle_q;
    assign bus.instr_count = instr_q;
    assign bus.final_pc    = fpc_q;

`ifdef SIM_RUN_CTRL_TRACE_EN
    localparam int unsigned TW = $clog2(TRACE_DEPTH);

    logic [PC_WIDTH-1:0] trace_mem [TRACE_DEPTH];
    logic [TW-1:0]       wr_ptr;
    logic [TW-1:0]       rd_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < TRACE_DEPTH; i++) trace_mem[i] <= '0;
            wr_ptr <= '0;
        end else if (start_accept) begin
            for (int unsigned i = 0; i < TRACE_DEPTH; i++) trace_mem[i] <= '0;
            wr_ptr <= '0;
        end else if (state_q == S_RUN && bus.retire) begin
            trace_mem[wr_ptr] <= bus.pc;
            wr_ptr            <= wr_ptr + TW'(1);
        end
    end

    // wr_ptr points at the next free slot, so the newest entry sits one behind it.
    assign rd_ptr       = wr_ptr - TW'(1) - bus.trace_idx;
    assign bus.trace_pc = trace_mem[rd_ptr];
`endif
endmodule

// File: tb/tb_sim_run_ctrl.sv
// Directed bench for sim_run_ctrl: table-driven start/halt sequence plus timeout, tie and reset sequences.
module tb_sim_run_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

`ifdef SIM_RUN_CTRL_TRACE_EN
    sim_run_ctrl_if #(.PC_WIDTH(32), .CNT_WIDTH(32), .TRACE_IDX_W(3)) bus ();
`else
    sim_run_ctrl_if #(.PC_WIDTH(32), .CNT_WIDTH(32)) bus ();
`endif

    sim_run_ctrl #(
        .PC_WIDTH(32), .CNT_WIDTH(32), .RST_CYCLES(2),
        .MAX_CYCLES(100), .HALT_REPEAT(4), .TRACE_DEPTH(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    typedef struct {
        logic        start;
        logic        retire;
        logic [31:0] pc;
        logic        cr;
        logic        run;
        logic        dn;
        logic        to;
        logic [31:0] cyc;
        logic [31:0] ins;
        logic [31:0] fpc;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic st, input logic rt, input logic [31:0] pc,
                                input logic cr, input logic run, input logic dn, input logic to,
                                input logic [31:0] cyc, input logic [31:0] ins, input logic [31:0] fpc);
        vec_t v;
        v.start = st; v.retire = rt; v.pc = pc;
        v.cr = cr; v.run = run; v.dn = dn; v.to = to;
        v.cyc = cyc; v.ins = ins; v.fpc = fpc;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic cr, input logic run, input logic dn,
                             input logic to, input logic [31:0] cyc, input logic [31:0] ins,
                             input logic [31:0] fpc);
        check({tag, " cpu_reset"}, 32'(bus.cpu_reset), 32'(cr));
        check({tag, " running"}, 32'(bus.running), 32'(run));
        check({tag, " done"}, 32'(bus.done), 32'(dn));
        check({tag, " timeout"}, 32'(bus.timeout), 32'(to));
        check({tag, " cycle_count"}, bus.cycle_count, cyc);
        check({tag, " instr_count"}, bus.instr_count, ins);
        check({tag, " final_pc"}, bus.final_pc, fpc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start  = 1'b0;
        bus.retire = 1'b0;
        bus.pc     = '0;
`ifdef SIM_RUN_CTRL_TRACE_EN
        bus.trace_idx = '0;
`endif

        // Idle after reset, then start, HOLD (start ignored), RUN with a gap and a halt loop.
        for (int i = 0; i < 10; i++) add(0, 0, 32'h0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 32'h0,    1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 32'h0,    1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 32'h0,    0, 1, 0, 0, 0, 0, 0);
        add(0, 1, 32'h3000, 0, 1, 0, 0, 1, 1, 0);
        add(1, 1, 32'h3004, 0, 1, 0, 0, 2, 2, 0);
        add(0, 1, 32'h3008, 0, 1, 0, 0, 3, 3, 0);
        add(0, 1, 32'h300c, 0, 1, 0, 0, 4, 4, 0);
        add(0, 1, 32'h300c, 0, 1, 0, 0, 5, 5, 0);
        add(0, 0, 32'hdead, 0, 1, 0, 0, 6, 5, 0);
        add(0, 1, 32'h300c, 0, 1, 0, 0, 7, 6, 0);
        add(0, 1, 32'h300c, 1, 0, 1, 0, 8, 7, 32'h300c);
        add(0, 1, 32'h300c, 1, 0, 1, 0, 8, 7, 32'h300c);
        add(0, 0, 32'h0,    1, 0, 1, 0, 8, 7, 32'h300c);

        #1 reset = 1'b0;
        repeat (3) step();
        check_all("reset", 1, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            bus.start  = vecs[i].start;
            bus.retire = vecs[i].retire;
            bus.pc     = vecs[i].pc;
            step();
            check_all($sformatf("vec%0d", i), vecs[i].cr, vecs[i].run, vecs[i].dn, vecs[i].to,
                      vecs[i].cyc, vecs[i].ins, vecs[i].fpc);
        end
        bus.start  = 1'b0;
        bus.retire = 1'b0;

`ifdef SIM_RUN_CTRL_TRACE_EN
        begin
            logic [2:0]  tidx [6] = '{3'd0, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
            logic [31:0] tval [6] = '{32'h300c, 32'h300c, 32'h3008, 32'h3004, 32'h3000, 32'h0};
            for (int i = 0; i < 6; i++) begin
                bus.trace_idx = tidx[i];
                #1;
                check($sformatf("trace idx%0d", tidx[i]), bus.trace_pc, tval[i]);
            end
        end
`endif

        // Timeout with a changing PC every cycle, then restart from TIMEOUT.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check_all("restart1", 1, 0, 0, 0, 0, 0, 0);
        step();
        step();
        check("run1 running", 32'(bus.running), 32'd1);
        for (int k = 1; k <= 100; k++) begin
            bus.retire = 1'b1;
            bus.pc     = 32'h1000 + 32'(4 * k);
            step();
            if (k == 99) check("pre-timeout flag", 32'(bus.timeout), 32'd0);
        end
        check_all("timeout", 1, 0, 0, 1, 100, 100, 0);
        step();
        check_all("timeout frozen", 1, 0, 0, 1, 100, 100, 0);
        bus.retire = 1'b0;
        bus.start  = 1'b1;
        step();
        bus.start = 1'b0;
        check_all("restart2", 1, 0, 0, 0, 0, 0, 0);
        step();
        step();
        check_all("run2 entry", 0, 1, 0, 0, 0, 0, 0);

        // Fourth identical retire lands on RUN cycle 100: halt beats timeout.
        for (int k = 1; k <= 100; k++) begin
            bus.retire = 1'b1;
            bus.pc     = (k >= 97) ? 32'h5000 : 32'h2000 + 32'(4 * k);
            step();
            if (k == 99) check("tie pre-halt done", 32'(bus.done), 32'd0);
        end
        bus.retire = 1'b0;
        check_all("tie", 1, 0, 1, 0, 100, 100, 32'h5000);
        step();
`ifdef SIM_RUN_CTRL_TRACE_EN
        bus.trace_idx = 3'd4;
        #1;
        check("trace tie idx4", bus.trace_pc, 32'h2180);
`endif

        // Asynchronous reset mid-RUN at cycle 40.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        for (int k = 1; k <= 40; k++) begin
            bus.retire = (k % 3) != 0;
            bus.pc     = 32'h7000 + 32'(4 * k);
            step();
        end
        bus.retire = 1'b0;
        check_all("cycle40", 0, 1, 0, 0, 40, 27, 0);
        #2 reset = 1'b0;
        #1;
        check_all("async reset", 1, 0, 0, 0, 0, 0, 0);
        step();
        step();
        reset = 1'b1;
        repeat (3) step();
        check_all("no resume", 1, 0, 0, 0, 0, 0, 0);

        // Fresh run: pc 0 matches the cleared last_pc, yet the first retire still counts as 1.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        check_all("run3 entry", 0, 1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            bus.retire = 1'b1;
            bus.pc     = 32'h0;
            step();
            if (k == 3) check("pc0 third retire done", 32'(bus.done), 32'd0);
        end
        bus.retire = 1'b0;
        check_all("pc0 halt", 1, 0, 1, 0, 4, 4, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sim_run_ctrl.md
Name: sim_run_ctrl

Overview:
Parametrised run controller for CPU simulation and FPGA bring-up. It sequences the CPU reset with a programmable hold length and watches the retire stream. It detects program end, meaning a jump-to-self loop, and flags a cycle-budget timeout. It sits between the top-level clock/reset and the CPU core, and exposes cycle and instruction counts plus the final PC.

Parameters:
PC_WIDTH, 32, width of pc and final_pc
CNT_WIDTH, 32, width of cycle_count and instr_count
RST_CYCLES, 2, cycles cpu_reset stays high after start (>=1)
MAX_CYCLES, 100, RUN-cycle budget before timeout; 0 disables timeout
HALT_REPEAT, 4, consecutive retires at an identical PC that mean halt (>=2)
TRACE_DEPTH, 8, PC trace entries, power of 2 (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a run (IDLE/DONE/TIMEOUT only)
pc  in  PC_WIDTH  PC of the instruction retiring this cycle
retire  in  1  qualifies pc; one instruction retired
cpu_reset  out  1  registered, active-high reset to the CPU core
running  out  1  high in RUN
done  out  1  sticky; halt loop detected
timeout  out  1  sticky; cycle budget exhausted
cycle_count  out  CNT_WIDTH  RUN cycles elapsed
instr_count  out  CNT_WIDTH  retires counted in RUN
final_pc  out  PC_WIDTH  PC of the halt loop; 0 otherwise

Behaviour:
- Reset and clocking: one clock; reset is asynchronous and active-low. While reset=0 all state clears immediately:
  - state=IDLE, cpu_reset=1
  - running, done, timeout = 0
  - counters, final_pc, repeat counter, last_pc = 0
- States: IDLE, HOLD, RUN, DONE, TIMEOUT.
- IDLE: cpu_reset=1. start=1 -> HOLD; hold counter loaded with RST_CYCLES.
- HOLD:
  - cpu_reset=1; hold counter decrements each cycle.
  - cpu_reset stays high for exactly RST_CYCLES cycles after the start edge.
  - On the edge the counter reaches 0 -> RUN; cpu_reset=0 and running=1 on that same edge.
- RUN:
  - cycle_count +1 every cycle, saturating at all-ones.
  - instr_count +1 per retire=1 cycle, saturating.
  - retire=0 cycles are ignored for halt detection.
- Halt detect (RUN, retire=1):
  - pc==last_pc: repeat counter +1.
  - Otherwise: repeat counter=1 and last_pc=pc.
  - The first retire after entering RUN always counts as 1.
  - When a retire brings the counter to HALT_REPEAT: next edge -> DONE, done=1, final_pc=pc.
  - The retire that triggers the halt is counted in instr_count.
- Timeout (RUN, MAX_CYCLES!=0): when cycle_count increments to MAX_CYCLES -> TIMEOUT, timeout=1 on that edge.
- Simultaneous halt and timeout on the same edge: DONE wins; timeout=0.
- DONE/TIMEOUT:
  - cpu_reset=1 reasserted on the transition edge; running=0.
  - Counters and final_pc frozen and held.
  - start=1 clears done, timeout, counters, final_pc and the halt tracker, then -> HOLD.
- start in HOLD or RUN is ignored.
- Reset low mid-operation: outputs return to reset values asynchronously. No run resumes until a fresh start after reset deasserts.
- Outputs are registers only; no combinational path from inputs to outputs.

Optional Feature:
Macro SIM_RUN_CTRL_TRACE_EN.
- Defined:
  - Adds ports trace_idx (in, log2(TRACE_DEPTH)) and trace_pc (out, PC_WIDTH).
  - A TRACE_DEPTH-entry ring buffer stores the PC of every retire in RUN; the write pointer wraps modulo TRACE_DEPTH.
  - trace_pc is combinational: trace_idx=0 gives the most recent retire, 1 the one before, and so on.
  - Entries never written read 0. The buffer clears on reset and on start.
  - Capture freezes in DONE/TIMEOUT.
- Undefined: these ports and the buffer do not exist; all other behaviour is identical.

Test Plan:
1. Hold reset=0 for 3 cycles, then release with no start for 10 cycles -> cpu_reset=1, running=done=timeout=0, both counts 0 throughout.
2. start pulse with RST_CYCLES=2 -> cpu_reset high exactly 2 cycles after the start edge, then 0; running=1 on the same edge.
3. Retire 0x3000, 0x3004, 0x3008, then 0x300c x4 (HALT_REPEAT=4):
   - done=1 on the edge after the 4th 0x300c; final_pc=0x300c; instr_count=7; cpu_reset=1; counts frozen.
   - With TRACE_EN: idx0=0x300c, idx4=0x3008, idx6=0x3000, idx7=0.
4. MAX_CYCLES=100, retire a changing PC every cycle -> timeout=1 when cycle_count=100; done=0; then a start pulse clears both flags and counts and re-enters HOLD.
5. Arrange the 4th identical retire to land on RUN cycle 100 -> done=1, timeout=0, final_pc valid.
6. Drive reset=0 mid-RUN at cycle 40 -> outputs take reset values before the next clock edge. After release and a start pulse, the run restarts from cycle_count=0.
